// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the radix-2 restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Controller <-> divider bundle: requests and operands in, stall/result out.
// Handshake: a request is taken while start_i=1 in IDLE and stays held while div_stall_o=1;
// result_valid_o is a one-cycle pulse, quotient_o/remainder_o hold until the next result.
interface div_unit_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();

  logic             start_i;
  logic             signed_div_i;
  logic             annul_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             div_stall_o;
  logic             result_valid_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  div_state_e       state_o;

  modport master (
    output start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
    input  div_stall_o, result_valid_o, quotient_o, remainder_o, state_o
  );

  modport slave (
    input  start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
    output div_stall_o, result_valid_o, quotient_o, remainder_o, state_o
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The extra top bit makes the borrow visible without overflow.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  assign o_rem = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division plus sign correction.
module div_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic             w_load;
  logic             w_last;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;

  assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_n),
    .o_quo     (w_quo_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      DIV_IDLE: if (bus.start_i) begin
        w_next_state = DIV_BUSY;
        w_load       = 1'b1;
      end
      DIV_BUSY: if (r_cnt == LAST_CNT) begin
        w_next_state = DIV_DONE;
        w_last       = 1'b1;
      end
      DIV_DONE: w_next_state = DIV_IDLE;
      default:  w_next_state = DIV_IDLE;
    endcase
    // Annul beats both a new start and the final BUSY->DONE step.
    if (bus.annul_i) begin
      w_next_state = DIV_IDLE;
      w_load       = 1'b0;
      w_last       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_load) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_abs1;
        r_div   <= w_abs2;
        r_neg_q <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
        r_neg_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      end else if (r_state == DIV_BUSY && !bus.annul_i) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
      end
      // Results are captured from the final iteration so they are ready in DONE.
      if (w_last) begin
        r_quotient  <= r_neg_q ? -w_quo_n : w_quo_n;
        r_remainder <= r_neg_r ? -w_rem_n : w_rem_n;
      end
    end
  end

  assign bus.div_stall_o    = bus.start_i & ~rst & (r_state != DIV_DONE);
  assign bus.result_valid_o = (r_state == DIV_DONE);
  assign bus.quotient_o     = r_quotient;
  assign bus.remainder_o    = r_remainder;
  assign bus.state_o        = r_state;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle radix-2 restoring divider for the execute stage. It implements DIV and DIVU.
- Consumes signed_divE and start_iE from the controller pipeline registers.
- Drives divstallE back to the controller, which freezes the ID/EX register while a division is in flight.
- Delivers quotient and remainder to the HI/LO write path.

Parameters:
WIDTH, 32, operand, quotient and remainder width.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start_i  input  1  division requested by the instruction in E (start_iE); held high while stalled
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (signed_divE)
annul_i  input  1  abandon the current operation (flushE | flush_except)
opdata1_i  input  WIDTH  dividend (rs value after forwarding)
opdata2_i  input  WIDTH  divisor (rt value after forwarding)
div_stall_o  output  1  stall request to the pipeline (divstallE)
result_valid_o  output  1  quotient and remainder valid this cycle
quotient_o  output  WIDTH  quotient, destined for LO
remainder_o  output  WIDTH  remainder, destined for HI

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, internal registers=0. Outputs: div_stall_o=0, result_valid_o=0, quotient_o=0, remainder_o=0.
- States: IDLE, BUSY, DONE. Encoding is 2-bit, defined in the package.
- IDLE:
  - If start_i=1 and annul_i=0, latch the operands:
    - |dividend| and |divisor|, where magnitude is taken only when signed_div_i=1.
    - neg_q = sign(dividend) XOR sign(divisor), signed only.
    - neg_r = sign(dividend), signed only.
  - Clear the counter and the partial remainder, then go to BUSY.
- BUSY, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and set quo[0]=1.
  - Increment the counter. After the iteration with counter == WIDTH-1, go to DONE.
- DONE:
  - result_valid_o=1 for exactly one cycle.
  - Outputs are sign-corrected: quotient negated if neg_q; remainder negated if neg_r.
  - Unconditionally return to IDLE on the next edge.
- div_stall_o = start_i AND NOT (state == DONE), combinational.
  - Stall is asserted from the cycle start_i first rises through the last BUSY cycle.
  - It drops in the DONE cycle so that the ID/EX register advances on that edge. The same instruction is therefore never restarted.
- Latency: start seen in cycle 0; BUSY in cycles 1..32; DONE in cycle 33. div_stall_o is high for 33 cycles.
- Operands are sampled only at IDLE->BUSY. Changes on opdata*_i afterwards are ignored.
- annul_i=1 in any state: next state is IDLE and no result_valid_o is produced. annul_i has priority over start_i and over BUSY->DONE.
- quotient_o and remainder_o hold the last DONE values until the next DONE; they are not cleared in IDLE.
- Divide by zero: no trap.
  - Unsigned: quotient=all ones, remainder=dividend.
  - Signed: the same magnitude result, then sign-corrected.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the magnitude arithmetic with no special case.
- Arithmetic: the partial remainder is WIDTH+1 bits, so the subtraction borrow is detected without overflow. Sign correction uses two's complement.

Decomposition:
- Package div_pkg holds:
  - the state typedef/constants DIV_IDLE, DIV_BUSY, DIV_DONE;
  - the DIV_WIDTH=32 and DIV_CNT_W=5 constants;
  - a DIV_ITERS constant.
- Sub-module div_restore_step is natural: combinational, one shift/trial-subtract iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- Everything else (FSM, counter, sign handling) stays in div_unit.

Test Plan:
- Unsigned 100/7: signed_div_i=0, start_i held high -> div_stall_o high for 33 cycles; DONE gives quotient 14, remainder 2, result_valid_o a single cycle.
- Signed -7/2: 0xFFFFFFF9 / 0x00000002 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Overflow and zero divisor:
  - signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0;
  - unsigned 5/0 -> quotient 0xFFFFFFFF, remainder 5, no hang.
- Annul: pulse annul_i in BUSY cycle 10 -> IDLE next cycle, no result_valid_o, outputs unchanged. A new start 2 cycles later completes 100/7 correctly.
- Back-to-back: after a DONE, a second start_i arrives the very next cycle with 0xFFFFFFFF/0x10 unsigned -> a second 33-cycle stall, quotient 0x0FFFFFFF, remainder 0xF. Verify the first operation is not repeated.
- Async reset: assert rst mid-BUSY, off a clock edge -> outputs go to 0 immediately; after release the state is IDLE and div_stall_o=0 while start_i=0.
